// File: rtl/mant_div8.sv
// rtl/mant_div8.sv - sequential unsigned restoring divider, one quotient bit per clock
module mant_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   rem_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] q_shift;
    logic             fits;
    logic             last_step;
    logic             div_zero;

    // One restoring step: shift in the next dividend bit, trial-subtract at full WIDTH+1 width
    always_comb begin
        trial     = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff      = trial - {1'b0, div_reg};
        fits      = (trial >= {1'b0, div_reg});
        rem_nxt   = fits ? diff : trial;
        q_shift   = {q_reg[WIDTH-2:0], fits};
        last_step = (cnt == CW'(WIDTH - 1));
        div_zero  = (div_reg == '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero divisor skips the iteration and finishes after one BUSY cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = BUSY;
            BUSY: if (div_zero || last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand capture, iteration, and result registers that only change on DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg     <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_reg <= divisor;
                        q_reg   <= dividend;
                        rem_reg <= '0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (div_zero) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        q_reg   <= q_shift;
                        rem_reg <= rem_nxt;
                        cnt     <= cnt + 1'b1;
                        if (last_step) begin
                            quotient    <= q_shift;
                            remainder   <= rem_nxt[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Restoring invariant: the partial remainder never reaches the divisor
    rem_in_range: assert property (@(posedge clk) disable iff (rst)
        (state == BUSY && !div_zero) |-> (rem_reg < {1'b0, div_reg}));

endmodule

// File: tb/tb_mant_div8.sv
// tb/tb_mant_div8.sv - directed and soak checks for mant_div8
module tb_mant_div8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total;
    int bad;

    mant_div8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation from IDLE, waits for out_valid with out_ready low, then handshakes it away
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                          output logic [7:0] q, output logic [7:0] r, output logic dz);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got rdy=%b vld=%b q=%0d r=%0d dz=%b want rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int  lat;
        logic rdy_seen;
        @(negedge clk);
        dividend  = 8'd200;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (in_ready !== 1'b0) rdy_seen = 1'b1;
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        total++;
        if (rdy_seen !== 1'b0) begin
            bad++;
            $display("FAIL basic_in_ready_busy got high want low");
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 8'd4, 1'b0}) begin
            bad++;
            $display("FAIL basic_200_7 got q=%0d r=%0d dz=%b want q=28 r=4 dz=0", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL basic_handshake got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_boundaries;
        logic [7:0] va [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
        logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        int lat;
        logic [7:0] q, r;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], lat, q, r, dz);
            total++;
            if ({lat[7:0], q, r, dz} !== {8'd8, eq[i], er[i], 1'b0}) begin
                bad++;
                $display("FAIL boundary_%0d_%0d got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=%0d r=%0d dz=0",
                         va[i], vb[i], lat, q, r, dz, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        logic [7:0] q, r;
        logic dz;
        run_op(8'd100, 8'd0, lat, q, r, dz);
        total++;
        if ({lat[7:0], q, r, dz} !== {8'd1, 8'd255, 8'd100, 1'b1}) begin
            bad++;
            $display("FAIL div_zero_100 got lat=%0d q=%0d r=%0d dz=%b want lat=1 q=255 r=100 dz=1", lat, q, r, dz);
        end
        run_op(8'd9, 8'd3, lat, q, r, dz);
        total++;
        if ({lat[7:0], q, r, dz} !== {8'd8, 8'd3, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL after_zero_9_3 got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=3 r=0 dz=0", lat, q, r, dz);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic changed;
        @(negedge clk);
        dividend  = 8'd37;
        divisor   = 8'd5;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        changed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, quotient, remainder, div_by_zero} !== {1'b1, 8'd7, 8'd2, 1'b0}) changed = 1'b1;
            @(negedge clk);
        end
        total++;
        if (changed !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_hold got vld=%b q=%0d r=%0d want held vld=1 q=7 r=2",
                     out_valid, quotient, remainder);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_isolation;
        int lat;
        logic rdy_seen;
        @(negedge clk);
        dividend  = 8'd123;
        divisor   = 8'd10;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            in_valid = ~in_valid;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b1;
        repeat (3) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
        end
        total++;
        if (rdy_seen !== 1'b0 || lat !== 8) begin
            bad++;
            $display("FAIL isolation_ready got rdy_seen=%b lat=%0d want rdy_seen=0 lat=8", rdy_seen, lat);
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd12, 8'd3, 1'b0}) begin
            bad++;
            $display("FAIL isolation_123_10 got q=%0d r=%0d dz=%b want q=12 r=3 dz=0", quotient, remainder, div_by_zero);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL isolation_not_queued got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_busy;
        int lat;
        logic [7:0] q, r;
        logic dz;
        @(negedge clk);
        dividend  = 8'd200;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_busy got rdy=%b vld=%b q=%0d r=%0d dz=%b want rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd50, 8'd6, lat, q, r, dz);
        total++;
        if ({lat[7:0], q, r, dz} !== {8'd8, 8'd8, 8'd2, 1'b0}) begin
            bad++;
            $display("FAIL after_reset_50_6 got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=8 r=2 dz=0", lat, q, r, dz);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int first;
        int gap;
        int seen;
        @(negedge clk);
        dividend  = 8'd77;
        divisor   = 8'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        first = -1;
        gap = -1;
        seen = 0;
        while (seen < 2 && cyc < 100) begin
            if (in_ready === 1'b1) begin
                if (first < 0) first = cyc;
                else gap = cyc - first;
                seen++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (gap !== 10) begin
            bad++;
            $display("FAIL back_to_back_gap got %0d want 10", gap);
        end
        while (in_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_soak;
        logic [16:0] exp_q[$];
        logic [16:0] want;
        logic [16:0] got;
        logic [7:0] a, b;
        int accepted;
        int results;
        int errs;
        int cyc;
        accepted = 0;
        results = 0;
        errs = 0;
        cyc = 0;
        @(negedge clk);
        while ((accepted < 1500 || exp_q.size() != 0) && cyc < 60000) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            dividend  = a;
            divisor   = b;
            in_valid  = (accepted < 1500) ? 1'($urandom) : 1'b0;
            out_ready = 1'($urandom);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got = {quotient, remainder, div_by_zero};
                if (exp_q.size() == 0) begin
                    errs++;
                    if (errs <= 5) $display("FAIL soak_extra_result got q=%0d r=%0d with nothing pending", quotient, remainder);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errs++;
                        if (errs <= 5) $display("FAIL soak_result got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                                                got[16:9], got[8:1], got[0], want[16:9], want[8:1], want[0]);
                    end
                end
                results++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                if (b == 8'd0) exp_q.push_back({8'd255, a, 1'b1});
                else exp_q.push_back({a / b, a % b, 1'b0});
                accepted++;
                if (exp_q.size() > 1) begin
                    errs++;
                    if (errs <= 5) $display("FAIL soak_overlap got %0d pending want at most 1", exp_q.size());
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL soak_errors got %0d want 0", errs);
        end
        total++;
        if (results !== 1500 || accepted !== 1500) begin
            bad++;
            $display("FAIL soak_count got accepted=%0d results=%0d want 1500 each", accepted, results);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_basic;
        test_boundaries;
        test_div_zero;
        test_backpressure;
        test_isolation;
        test_reset_mid_busy;
        test_back_to_back;
        test_soak;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
